// File: rtl/prim_esc_pkg.sv
// Shared types for the escalation sender/receiver pair: differential wire bundles
// and the responder state encoding.
package prim_esc_pkg;

    typedef struct packed {
        logic esc_p;
        logic esc_n;
    } esc_tx_t;

    typedef struct packed {
        logic resp_p;
        logic resp_n;
    } esc_rx_t;

    typedef enum logic [2:0] {
        Idle     = 3'd0,
        Check    = 3'd1,
        PingResp = 3'd2,
        EscResp  = 3'd3,
        SigInt   = 3'd4
    } esc_resp_state_e;

endpackage

// File: rtl/prim_esc_timeout_cnt.sv
// Saturating cycle counter with clear priority; hit flags the cycle in which the
// count steps onto Threshold (never asserted when Threshold is 0).
module prim_esc_timeout_cnt #(
    parameter int unsigned Threshold = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic hit
);

    localparam int unsigned CntW = (Threshold > 0) ? $clog2(Threshold + 1) : 1;
    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] CntThr = CntW'(Threshold);

    logic [CntW-1:0] count;
    logic [CntW-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != CntMax)) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign hit = (Threshold != 0) && (count_next == CntThr);

endmodule

// File: rtl/esc_responder.sv
// Escalation receiver: answers pings, asserts the local escalation enable, and flags
// differential integrity errors back to the sender through the response pair.
module esc_responder
    import prim_esc_pkg::*;
#(
    parameter int unsigned PingTimeoutCycles = 0
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  esc_tx_t esc_tx_i,
    output esc_rx_t esc_rx_o,
    output logic    esc_en_o
);

    logic esc_level;
    logic sig_err;

    esc_resp_state_e state;
    esc_resp_state_e state_next;

    logic resp_p, resp_n;
    logic resp_p_next, resp_n_next;
    logic fsm_en;
    logic en, en_next;
    logic timeout, timeout_next;
    logic cnt_enable, cnt_clear, cnt_hit;

    assign esc_level = esc_tx_i.esc_p & ~esc_tx_i.esc_n;
    assign sig_err   = (esc_tx_i.esc_p == esc_tx_i.esc_n);

    always_comb begin
        state_next  = state;
        resp_p_next = 1'b0;
        resp_n_next = 1'b1;
        fsm_en      = 1'b0;
        if (sig_err) begin
            // Equal response wires tell the sender its lines look broken.
            state_next  = SigInt;
            resp_p_next = (state == SigInt) ? ~resp_p : 1'b1;
            resp_n_next = (state == SigInt) ? ~resp_p : 1'b1;
        end else begin
            unique case (state)
                Idle: begin
                    if (esc_level) begin
                        state_next  = Check;
                        resp_p_next = 1'b1;
                        resp_n_next = 1'b0;
                    end
                end
                Check: begin
                    if (esc_level) begin
                        state_next = EscResp;
                        fsm_en     = 1'b1;
                    end else begin
                        state_next = PingResp;
                    end
                end
                PingResp: begin
                    state_next  = Idle;
                    resp_p_next = 1'b1;
                    resp_n_next = 1'b0;
                end
                EscResp: begin
                    if (esc_level) begin
                        resp_p_next = ~resp_p;
                        resp_n_next = resp_p;
                        fsm_en      = 1'b1;
                    end else begin
                        state_next = Idle;
                    end
                end
                SigInt: begin
                    if (esc_level) begin
                        state_next  = Check;
                        resp_p_next = 1'b1;
                        resp_n_next = 1'b0;
                    end else begin
                        state_next = Idle;
                    end
                end
                default: state_next = Idle;
            endcase
        end
    end

    // Idle time counts toward the ping-absence timeout; leaving Idle restarts it.
    assign cnt_enable = (state == Idle);
    assign cnt_clear  = (state == Idle) && (state_next != Idle);

    prim_esc_timeout_cnt #(
        .Threshold(PingTimeoutCycles)
    ) u_timeout_cnt (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .enable (cnt_enable),
        .clear  (cnt_clear),
        .hit    (cnt_hit)
    );

    assign timeout_next = timeout | cnt_hit;
    assign en_next      = fsm_en | timeout_next;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= Idle;
            resp_p  <= 1'b0;
            resp_n  <= 1'b1;
            en      <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            resp_p  <= resp_p_next;
            resp_n  <= resp_n_next;
            en      <= en_next;
            timeout <= timeout_next;
        end
    end

    assign esc_rx_o.resp_p = resp_p;
    assign esc_rx_o.resp_n = resp_n;
    assign esc_en_o        = en;

endmodule

// File: tb/tb_esc_responder.sv
// Bench for esc_responder: vector table, timeout sequences, and randomized traffic
// against a transition-level reference model (one instance without, one with timeout).
module tb_esc_responder;
    import prim_esc_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_CHECK = 1;
    localparam int M_PING  = 2;
    localparam int M_ESC   = 3;
    localparam int M_ERR   = 4;
    localparam int TO_THR  = 8;

    typedef struct {
        logic p;
        logic n;
        logic r;
        logic ep;
        logic en_n;
        logic een;
    } vec_t;

    typedef struct {
        int   mode;
        logic rp;
        logic rn;
        logic fen;
        int   idle_run;
        logic to;
    } model_t;

    logic    clk = 1'b0;
    logic    rst_n, rst_to_n;
    esc_tx_t tx, tx_to;
    esc_rx_t rx, rx_to;
    logic    en, en_to;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t   vecs[$];
    model_t ms0, ms8;

    always #5 clk = ~clk;

    esc_responder #(.PingTimeoutCycles(0)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .esc_tx_i (tx),
        .esc_rx_o (rx),
        .esc_en_o (en)
    );

    esc_responder #(.PingTimeoutCycles(TO_THR)) dut_to (
        .clk_i    (clk),
        .rst_ni   (rst_to_n),
        .esc_tx_i (tx_to),
        .esc_rx_o (rx_to),
        .esc_en_o (en_to)
    );

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got resp_p/resp_n/en=%b required %b", name, act, exp);
        end
    endtask

    // Drive both instances, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic p, input logic n, input logic r,
                       input logic q, input logic m, input logic s);
        tx.esc_p    = p;
        tx.esc_n    = n;
        rst_n       = r;
        tx_to.esc_p = q;
        tx_to.esc_n = m;
        rst_to_n    = s;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic p, input logic n, input logic r,
                                input logic ep, input logic en_n, input logic een);
        vec_t v;
        v.p = p; v.n = n; v.r = r; v.ep = ep; v.en_n = en_n; v.een = een;
        vecs.push_back(v);
    endfunction

    // Behavioural reference: each step picks where the receiver goes, and the
    // response bits follow from which step was taken.
    function automatic model_t model_step(input model_t s, input int thr,
                                          input logic p, input logic n, input logic r);
        model_t o;
        logic lvl, err;
        o   = s;
        lvl = p & ~n;
        err = (p == n);
        if (!r) begin
            o.mode = M_IDLE; o.rp = 1'b0; o.rn = 1'b1; o.fen = 1'b0;
            o.idle_run = 0; o.to = 1'b0;
            return o;
        end
        o.fen = 1'b0;
        if (err) begin
            o.mode = M_ERR;
            o.rp   = (s.mode == M_ERR) ? ~s.rp : 1'b1;
            o.rn   = o.rp;
        end else begin
            case (s.mode)
                M_IDLE, M_ERR: o.mode = lvl ? M_CHECK : M_IDLE;
                M_CHECK:       o.mode = lvl ? M_ESC : M_PING;
                M_PING:        o.mode = M_IDLE;
                default:       o.mode = lvl ? M_ESC : M_IDLE;
            endcase
            if (o.mode == M_ESC) begin
                o.rp  = (s.mode == M_ESC) ? ~s.rp : 1'b0;
                o.fen = 1'b1;
            end else if (o.mode == M_CHECK || s.mode == M_PING) begin
                o.rp = 1'b1;
            end else begin
                o.rp = 1'b0;
            end
            o.rn = ~o.rp;
        end
        if (s.mode == M_IDLE) o.idle_run = (o.mode == M_IDLE) ? s.idle_run + 1 : 0;
        if (thr > 0 && o.idle_run >= thr) o.to = 1'b1;
        return o;
    endfunction

    function automatic void pick(input int idle_pct, input int esc_pct, input int rst_pct,
                                 output logic p, output logic n, output logic r);
        int k;
        k = $urandom_range(0, 99);
        if (k < idle_pct) begin
            p = 1'b0; n = 1'b1;
        end else if (k < idle_pct + esc_pct) begin
            p = 1'b1; n = 1'b0;
        end else begin
            p = $urandom_range(0, 1); n = p;
        end
        r = ($urandom_range(0, 99) >= rst_pct);
    endfunction

    initial begin
        logic exp_en;
        logic p0, n0, r0, p8, n8, r8;

        // Reset state of both instances.
        cyc(1, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        check("reset_dut", {rx.resp_p, rx.resp_n, en}, 3'b010);
        check("reset_dut_to", {rx_to.resp_p, rx_to.resp_n, en_to}, 3'b010);

        // Ping
        add(1,0,1, 1,0,0); add(0,1,1, 0,1,0); add(0,1,1, 1,0,0); add(0,1,1, 0,1,0);
        add(0,1,1, 0,1,0);
        // Six-cycle escalation
        add(1,0,1, 1,0,0); add(1,0,1, 0,1,1); add(1,0,1, 1,0,1); add(1,0,1, 0,1,1);
        add(1,0,1, 1,0,1); add(1,0,1, 0,1,1); add(0,1,1, 0,1,0);
        // Integrity error from Idle
        add(1,1,1, 1,1,0); add(1,1,1, 0,0,0); add(1,1,1, 1,1,0); add(0,1,1, 0,1,0);
        // Integrity error from EscResp
        add(1,0,1, 1,0,0); add(1,0,1, 0,1,1); add(1,1,1, 1,1,0); add(1,1,1, 0,0,0);
        add(1,1,1, 1,1,0); add(0,1,1, 0,1,0);
        // SigInt straight into a ping, and 0/0 as an error
        add(1,1,1, 1,1,0); add(1,0,1, 1,0,0); add(0,1,1, 0,1,0); add(0,1,1, 1,0,0);
        add(0,0,1, 1,1,0); add(0,1,1, 0,1,0);
        // Ping arriving during PingResp
        add(1,0,1, 1,0,0); add(0,1,1, 0,1,0); add(1,0,1, 1,0,0); add(1,0,1, 1,0,0);
        add(0,1,1, 0,1,0); add(0,1,1, 1,0,0); add(0,1,1, 0,1,0);
        // Reset mid-escalation, then a clean ping from Idle
        add(1,0,1, 1,0,0); add(1,0,1, 0,1,1); add(1,0,0, 0,1,0); add(0,1,1, 0,1,0);
        add(1,0,1, 1,0,0); add(0,1,1, 0,1,0); add(0,1,1, 1,0,0); add(0,1,1, 0,1,0);
        // Reset mid-SigInt
        add(1,1,1, 1,1,0); add(1,1,0, 0,1,0); add(0,1,1, 0,1,0);

        foreach (vecs[i]) begin
            cyc(vecs[i].p, vecs[i].n, vecs[i].r, 0, 1, 0);
            check($sformatf("vec[%0d]", i), {rx.resp_p, rx.resp_n, en},
                  {vecs[i].ep, vecs[i].en_n, vecs[i].een});
        end

        // Timeout with no ping.
        cyc(0, 1, 1, 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 1, 1, 0, 1, 1);
            exp_en = (k >= TO_THR);
            check($sformatf("timeout_c%0d", k), {rx_to.resp_p, rx_to.resp_n, en_to},
                  {1'b0, 1'b1, exp_en});
        end
        // Ping after timeout: pattern intact, enable held.
        cyc(0, 1, 1, 1, 0, 1);
        check("to_ping0", {rx_to.resp_p, rx_to.resp_n, en_to}, 3'b101);
        cyc(0, 1, 1, 0, 1, 1);
        check("to_ping1", {rx_to.resp_p, rx_to.resp_n, en_to}, 3'b011);
        cyc(0, 1, 1, 0, 1, 1);
        check("to_ping2", {rx_to.resp_p, rx_to.resp_n, en_to}, 3'b101);
        cyc(0, 1, 1, 0, 1, 1);
        check("to_ping3", {rx_to.resp_p, rx_to.resp_n, en_to}, 3'b011);

        // Ping at cycle 5 restarts the count; timeout only 8 Idle cycles after return.
        cyc(0, 1, 1, 0, 1, 0);
        check("to_reset", {rx_to.resp_p, rx_to.resp_n, en_to}, 3'b010);
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) cyc(0, 1, 1, 1, 0, 1);
            else        cyc(0, 1, 1, 0, 1, 1);
            exp_en = (k == 15);
            check($sformatf("ping5_en_c%0d", k), {1'b0, 1'b0, en_to}, {1'b0, 1'b0, exp_en});
        end

        // Randomized traffic against the reference model.
        cyc(0, 1, 0, 0, 1, 0);
        ms0 = model_step(ms0, 0, 0, 1, 0);
        ms8 = model_step(ms8, TO_THR, 0, 1, 0);
        for (int c = 0; c < 2000; c++) begin
            pick(55, 30, 2, p0, n0, r0);
            pick(75, 17, 3, p8, n8, r8);
            cyc(p0, n0, r0, p8, n8, r8);
            ms0 = model_step(ms0, 0, p0, n0, r0);
            ms8 = model_step(ms8, TO_THR, p8, n8, r8);
            check($sformatf("rand0_c%0d", c), {rx.resp_p, rx.resp_n, en},
                  {ms0.rp, ms0.rn, ms0.fen | ms0.to});
            check($sformatf("rand8_c%0d", c), {rx_to.resp_p, rx_to.resp_n, en_to},
                  {ms8.rp, ms8.rn, ms8.fen | ms8.to});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
